// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: opcodes, fault codes
// and FSM state encoding.
package pc_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OVF  = 2'd1;
  localparam logic [1:0] FC_UNF  = 2'd2;
  localparam logic [1:0] FC_ILL  = 2'd3;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: decodes control opcodes, computes the next PC and
// drives an external return-address stack, with overflow/underflow/illegal fault detection.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DEPTH        = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               op,
  input  logic [ADDR_W-1:0]        target,
  input  logic                     cond,
  input  logic                     resume,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [ADDR_W-1:0]        stk_wdata,
  input  logic [ADDR_W-1:0]        stk_rdata,
  input  logic                     stk_empty,
  input  logic                     stk_full,
  output logic [ADDR_W-1:0]        pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     halted,
  output logic                     fault,
  output logic [1:0]               fault_code
);

  localparam int DW = $clog2(DEPTH) + 1;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s, pc_inc_s;
  logic [DW-1:0]     depth_r, depth_nxt_s;
  logic [1:0]        fc_r, fc_nxt_s;
  logic              act_s, push_s, pop_s;

  assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state, next-PC and stack strobe decode; rst gates the strobes so a
  // reset edge never commits a push or pop.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    depth_nxt_s = depth_r;
    fc_nxt_s    = fc_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    act_s       = (state_r == S_RUN) && en && rst;
    case (state_r)
      S_RUN: begin
        if (act_s) begin
          case (op)
            OP_NOP:  pc_nxt_s = pc_r;
            OP_INC:  pc_nxt_s = pc_inc_s;
            OP_JMP:  pc_nxt_s = target;
            OP_BR: begin
              if (cond) pc_nxt_s = target;
              else      pc_nxt_s = pc_inc_s;
            end
            OP_CALL: begin
              if (stk_full) begin
                state_nxt_s = S_FAULT;
                fc_nxt_s    = FC_OVF;
              end else begin
                push_s      = 1'b1;
                pc_nxt_s    = target;
                depth_nxt_s = depth_r + {{(DW-1){1'b0}}, 1'b1};
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_nxt_s = S_FAULT;
                fc_nxt_s    = FC_UNF;
              end else begin
                pop_s       = 1'b1;
                pc_nxt_s    = stk_rdata;
                depth_nxt_s = depth_r - {{(DW-1){1'b0}}, 1'b1};
              end
            end
            OP_HALT: state_nxt_s = S_HALT;
            OP_ILL: begin
              state_nxt_s = S_FAULT;
              fc_nxt_s    = FC_ILL;
            end
            default: begin
              state_nxt_s = S_FAULT;
              fc_nxt_s    = FC_ILL;
            end
          endcase
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_HALT;
        end
      end
      S_FAULT: state_nxt_s = S_FAULT;
      default: state_nxt_s = S_FAULT;
    endcase
  end

  // State, PC, depth and fault-code registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_RUN;
      pc_r    <= RESET_VECTOR;
      depth_r <= {DW{1'b0}};
      fc_r    <= FC_NONE;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      depth_r <= depth_nxt_s;
      fc_r    <= fc_nxt_s;
    end
  end

  assign stk_push   = push_s;
  assign stk_pop    = pop_s;
  assign stk_wdata  = pc_inc_s;
  assign pc         = pc_r;
  assign depth      = depth_r;
  assign halted     = (state_r == S_HALT);
  assign fault      = (state_r == S_FAULT);
  assign fault_code = fc_r;

endmodule
